// File: rtl/output_stream_buffer.sv
// Result buffer between accumulator outputs and the external valid/ready port.
// Holds DEPTH entries with per-entry valid bits and serves single reads or wrapping burst drains.
module output_stream_buffer #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int CLR_ON_READ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_len,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [ADDR_W:0]   occupancy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SINGLE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]              state;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]        vld, vld_nxt;
  logic [ADDR_W:0]         occ_nxt;
  logic [ADDR_W-1:0]       ptr, ptr_inc;
  logic [ADDR_W:0]         remaining;
  logic                    hs;

  assign hs      = res_valid & res_ready;
  assign busy    = (state != IDLE);
  assign ptr_inc = ptr + ADDR_W'(1);

  // Clear-on-send first, then write, so a same-edge write keeps the entry valid.
  always_comb begin
    vld_nxt = vld;
    if (CLR_ON_READ != 0 && hs) vld_nxt[ptr] = 1'b0;
    if (wr_en) vld_nxt[wr_addr] = 1'b1;
  end

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + (ADDR_W+1)'(vld_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld       <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      vld       <= vld_nxt;
      occupancy <= occ_nxt;
    end
  end

  // Reads sample mem before this edge's write lands, so same-edge collisions see old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_start && drain_len != '0) begin
            state     <= DRAIN;
            ptr       <= drain_base;
            remaining <= drain_len;
            res_data  <= mem[drain_base];
            res_valid <= 1'b1;
          end else if (rd_req) begin
            state     <= SINGLE;
            ptr       <= rd_addr;
            remaining <= (ADDR_W+1)'(1);
            res_data  <= mem[rd_addr];
            res_valid <= 1'b1;
          end
        end
        SINGLE: begin
          if (hs) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (hs) begin
            remaining <= remaining - (ADDR_W+1)'(1);
            ptr       <= ptr_inc;
            if (remaining > (ADDR_W+1)'(1)) begin
              res_data <= mem[ptr_inc];
            end else begin
              res_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_stream_buffer.sv
// Self-checking bench for output_stream_buffer: directed scenarios plus randomized
// requests compared against a transaction-level model of memory and valid bits.
module tb_output_stream_buffer;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk, rst;
  logic          wr_en, rd_req, drain_start, res_ready;
  logic [AW-1:0] wr_addr, rd_addr, drain_base;
  logic [AW:0]   drain_len;
  logic [DW-1:0] wr_data, res_data;
  logic          res_valid, busy;
  logic [AW:0]   occupancy;

  output_stream_buffer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .CLR_ON_READ(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .drain_start(drain_start),
    .drain_base(drain_base), .drain_len(drain_len), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mem_m [DP];
  bit            vld_m [DP];
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] exp_q [$];
  int            busy_cyc;
  bit            timed_out;

  function automatic int pop_m();
    int c = 0;
    for (int i = 0; i < DP; i++) c += int'(vld_m[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    mem_m[a] = d; vld_m[a] = 1'b1;
  endtask

  task automatic start_drain(input int base, input int len);
    drain_start = 1'b1; drain_base = AW'(base); drain_len = (AW+1)'(len);
    tick();
    drain_start = 1'b0;
  endtask

  task automatic start_single(input int a);
    rd_req = 1'b1; rd_addr = AW'(a);
    tick();
    rd_req = 1'b0;
  endtask

  // Collects transferred beats until busy drops; mode 0 ready=1, 1 toggle, 2 random.
  task automatic collect(input int mode);
    int cyc = 0;
    got_q.delete(); busy_cyc = 0; timed_out = 0;
    while (busy) begin
      if (cyc >= 200) begin timed_out = 1; break; end
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = (cyc % 2 == 0);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      busy_cyc++;
      if (res_valid && res_ready) got_q.push_back(res_data);
      tick();
      cyc++;
    end
    res_ready = 1'b0;
  endtask

  function automatic void expect_burst(input int base, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem_m[(base + i) % DP]);
  endfunction

  function automatic void retire_burst(input int base, input int len);
    for (int i = 0; i < len; i++) vld_m[(base + i) % DP] = 1'b0;
  endfunction

  function automatic bit queues_match();
    if (timed_out || got_q.size() != exp_q.size()) return 0;
    for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) return 0;
    return 1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_chk++;
    if ({res_valid, busy, occupancy, res_data} !== '0)
      $display("FAIL reset_outputs: got v=%b b=%b occ=%0d d=%h, want all 0", res_valid, busy, occupancy, res_data);
    else n_pass++;
    for (int i = 0; i < DP; i++) begin mem_m[i] = '0; vld_m[i] = 1'b0; end
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr(3, 32'hDEADBEEF);
    n_chk++;
    if (occupancy !== 5'd1) $display("FAIL single_occ_after_write: got %0d want 1", occupancy);
    else n_pass++;
    res_ready = 1'b1;
    start_single(3);
    n_chk++;
    if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 32'hDEADBEEF)
      $display("FAIL single_first_beat: got v=%b b=%b d=%h want v=1 b=1 d=deadbeef", res_valid, busy, res_data);
    else n_pass++;
    expect_burst(3, 1);
    collect(0);
    retire_burst(3, 1);
    n_chk++;
    if (!queues_match() || busy_cyc != 1 || res_valid !== 1'b0)
      $display("FAIL single_one_cycle: got beats=%0d cycles=%0d v=%b want 1/1/0", got_q.size(), busy_cyc, res_valid);
    else n_pass++;
    n_chk++;
    if (occupancy !== 5'(pop_m())) $display("FAIL single_occ_clear: got %0d want %0d", occupancy, pop_m());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int held_ok = 1;
    wr(5, 32'h55);
    res_ready = 1'b0;
    start_single(5);
    for (int c = 0; c < 4; c++) begin
      if (res_valid !== 1'b1 || res_data !== 32'h55) held_ok = 0;
      tick();
    end
    n_chk++;
    if (!held_ok || res_valid !== 1'b1 || res_data !== 32'h55)
      $display("FAIL bp_hold: got v=%b d=%h want v=1 d=55 through stall", res_valid, res_data);
    else n_pass++;
    exp_q.delete(); exp_q.push_back(32'h55);
    collect(0);
    vld_m[5] = 1'b0;
    n_chk++;
    if (!queues_match()) $display("FAIL bp_one_transfer: got %0d beats want 1", got_q.size());
    else n_pass++;
    n_chk++;
    if (occupancy !== 5'(pop_m())) $display("FAIL bp_occ: got %0d want %0d", occupancy, pop_m());
    else n_pass++;
  endtask

  task automatic test_wrap_burst();
    for (int a = 0; a < DP; a++) wr(a, DW'(a));
    n_chk++;
    if (occupancy !== 5'd16) $display("FAIL wrap_full_occ: got %0d want 16", occupancy);
    else n_pass++;
    res_ready = 1'b1;
    start_drain(14, 4);
    expect_burst(14, 4);
    collect(0);
    retire_burst(14, 4);
    n_chk++;
    if (!queues_match() || busy_cyc != 4)
      $display("FAIL wrap_beats: got beats=%0d cycles=%0d want 4/4 (14,15,0,1)", got_q.size(), busy_cyc);
    else n_pass++;
    n_chk++;
    if (occupancy !== 5'(pop_m())) $display("FAIL wrap_occ: got %0d want %0d", occupancy, pop_m());
    else n_pass++;
  endtask

  task automatic test_burst_stalls();
    start_drain(0, 3);
    expect_burst(0, 3);
    collect(1);
    retire_burst(0, 3);
    n_chk++;
    if (!queues_match() || busy_cyc != 5)
      $display("FAIL stall_beats: got beats=%0d cycles=%0d want 3/5", got_q.size(), busy_cyc);
    else n_pass++;
  endtask

  task automatic test_collision();
    int occ_before;
    wr(2, 32'h7);
    res_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hA;
    rd_req = 1'b1; rd_addr = 4'd2;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    mem_m[2] = 32'hA; vld_m[2] = 1'b1;
    n_chk++;
    if (res_data !== 32'h7) $display("FAIL coll_old_data: got %h want 00000007", res_data);
    else n_pass++;
    occ_before = pop_m();
    res_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hB;
    tick();
    wr_en = 1'b0; res_ready = 1'b0;
    mem_m[2] = 32'hB;
    n_chk++;
    if (res_valid !== 1'b0 || occupancy !== 5'(occ_before))
      $display("FAIL coll_valid_kept: got v=%b occ=%0d want v=0 occ=%0d", res_valid, occupancy, occ_before);
    else n_pass++;
  endtask

  task automatic test_ignored_abort();
    res_ready = 1'b0;
    start_drain(4, 3);
    rd_req = 1'b1; rd_addr = 4'd9;
    tick();
    rd_req = 1'b0;
    expect_burst(4, 3);
    collect(0);
    retire_burst(4, 3);
    tick(); tick();
    n_chk++;
    if (!queues_match() || res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ignored_rdreq: got beats=%0d v=%b b=%b want 3/0/0", got_q.size(), res_valid, busy);
    else n_pass++;
    start_drain(6, 0);
    n_chk++;
    if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL len0_noop: got b=%b v=%b want 0/0", busy, res_valid);
    else n_pass++;
    drain_start = 1'b1; drain_len = '0; rd_req = 1'b1; rd_addr = 4'd8;
    tick();
    drain_start = 1'b0; rd_req = 1'b0;
    n_chk++;
    if (res_valid !== 1'b1 || res_data !== mem_m[8])
      $display("FAIL len0_with_rdreq: got v=%b d=%h want v=1 d=%h", res_valid, res_data, mem_m[8]);
    else n_pass++;
    collect(0);
    vld_m[8] = 1'b0;
    res_ready = 1'b1;
    start_drain(0, 8);
    tick();
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (res_valid !== 1'b0 || occupancy !== '0 || busy !== 1'b0 || res_data !== '0)
      $display("FAIL reset_abort: got v=%b occ=%0d b=%b d=%h want all 0", res_valid, occupancy, busy, res_data);
    else n_pass++;
    for (int i = 0; i < DP; i++) begin mem_m[i] = '0; vld_m[i] = 1'b0; end
    #2 rst = 1'b1;
    tick(); tick();
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_no_more_beats: got v=%b b=%b want 0/0", res_valid, busy);
    else n_pass++;
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int nw, base, len;
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, DP-1), $urandom);
      base = $urandom_range(0, DP-1);
      if ($urandom_range(0, 2) == 0) begin
        len = 1;
        expect_burst(base, 1);
        start_single(base);
      end else begin
        len = $urandom_range(1, DP);
        expect_burst(base, len);
        start_drain(base, len);
      end
      collect(2);
      retire_burst(base, len);
      n_chk++;
      if (!queues_match())
        $display("FAIL rand_beats it=%0d: got %0d beats (first %h) want %0d (first %h)",
                 it, got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0, exp_q.size(), exp_q[0]);
      else n_pass++;
      n_chk++;
      if (occupancy !== 5'(pop_m())) $display("FAIL rand_occ it=%0d: got %0d want %0d", it, occupancy, pop_m());
      else n_pass++;
    end
  endtask

  initial begin
    wr_en = 1'b0; rd_req = 1'b0; drain_start = 1'b0; res_ready = 1'b0;
    wr_addr = '0; rd_addr = '0; drain_base = '0; drain_len = '0; wr_data = '0;
    rst = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap_burst();
    test_burst_stalls();
    test_collision();
    test_ignored_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/output_stream_buffer.md
# output_stream_buffer

Parametrised result buffer between the systolic array's accumulator outputs and the external interface. It is the next generation of the 16×32-bit output buffer: width and depth are parameters, and the external side uses a valid/ready handshake instead of a fire-and-forget register. It supports single-entry reads and multi-entry burst drains with address wrap, tracks per-entry valid bits, and reports occupancy.

## Interface
- DATA_W, 32, entry and output data width
- DEPTH, 16, number of entries; power of two, ≥2
- ADDR_W, $clog2(DEPTH), address width
- CLR_ON_READ, 1, 1: a sent entry's valid bit clears on its handshake; 0: valid bits clear only on reset
- clk  in  1  clock; all logic is posedge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  store wr_data at wr_addr this cycle
- wr_addr  in  ADDR_W  store address
- wr_data  in  DATA_W  store data
- rd_req  in  1  single-entry send request; sampled only in IDLE
- rd_addr  in  ADDR_W  single-entry address
- drain_start  in  1  burst send request; sampled only in IDLE
- drain_base  in  ADDR_W  first burst address
- drain_len  in  ADDR_W+1  burst beat count, 1..DEPTH; 0 is a no-op
- res_data  out  DATA_W  external data, registered
- res_valid  out  1  res_data is valid
- res_ready  in  1  external side accepts; a beat transfers on res_valid & res_ready at a rising edge
- busy  out  1  FSM not in IDLE
- occupancy  out  ADDR_W+1  count of entries with the valid bit set

## Operation
- Storage: DEPTH×DATA_W array plus a DEPTH-bit valid vector. A write sets the entry and its valid bit. Writes are accepted in every state.
- FSM states: IDLE, SINGLE, DRAIN.
- IDLE: drain_start with drain_len≠0 → DRAIN; pointer = drain_base, remaining = drain_len. Otherwise rd_req → SINGLE. drain_start has priority over rd_req. drain_start with drain_len=0 does nothing; a simultaneous rd_req is then serviced.
- Entering SINGLE or DRAIN loads res_data with buf[addr] and sets res_valid.
- SINGLE: hold res_data and res_valid until handshake, then clear res_valid and return to IDLE.
- DRAIN: on each handshake, decrement remaining and increment the pointer modulo DEPTH, so base DEPTH-1 wraps to 0. If remaining>1, load the next entry in the same edge and keep res_valid=1. On the last beat, clear res_valid and return to IDLE.
- rd_req and drain_start are ignored outside IDLE; no queuing.
- Read/write same address, same edge: the read captures the old data. The written value is visible from the next cycle.
- Reads of an entry whose valid bit is clear still return stored data; there is no error flag.
- CLR_ON_READ=1: on a handshake, clear that entry's valid bit. If a write to the same entry occurs on the same edge, the write wins and the valid bit stays 1.
- occupancy = popcount of the valid vector, registered and updated in the same edge as the vector.

## Timing
- Reset asserted (async): all entries 0, valid vector 0, res_data=0, res_valid=0, busy=0, occupancy=0, FSM=IDLE.
- Reset mid-burst: the burst aborts immediately with the same values; no further beats.
- Request at edge N (IDLE) → res_valid=1 and busy=1 from after edge N.
- res_data and res_valid stay stable while res_valid=1 and res_ready=0.
- With res_ready held high, a burst sends 1 beat per cycle: drain_len=L occupies L cycles after the start edge.
- busy falls after the final handshake edge. A new request is accepted on the first cycle busy=0, so the minimum gap between a burst end and the next first beat is one cycle.
- A write at edge N is readable by a request sampled at edge N+1.

## Test plan
- Reset/store/single read: hold reset, then write 0xDEADBEEF@3 and pulse rd_req addr 3 with res_ready=1. Required: res_valid for one cycle with 0xDEADBEEF; occupancy 1→0 (CLR_ON_READ=1).
- Backpressure: single read of addr 5 (0x55) with res_ready=0 for 4 cycles, then 1. Required: res_data held at 0x55 and res_valid=1 for all 5 cycles; exactly one transfer.
- Wrapped burst: fill 0..15 with value=addr, then drain_base=14, drain_len=4, res_ready=1. Required: beats 14,15,0,1 on consecutive cycles; busy=1 for 4 cycles.
- Burst with stalls: drain_base=0, drain_len=3, res_ready toggling 1,0,1,0,1. Required: beats 0,1,2 each transferred once, in order, with no duplicates.
- Collisions: write 0xA@2 and rd_req addr 2 in the same cycle, old value 0x7. Required: output 0x7. Then a handshake on addr 2 coincides with a write to addr 2: valid bit stays set and occupancy is unchanged.
- Ignored requests and reset abort: issue rd_req during a burst → ignored. drain_len=0 → busy stays 0. Assert reset mid-burst → res_valid=0, occupancy=0 immediately.
